router_fsm: RTL and testbench

Packet-level control state machine for the 1x3 router. It decodes the header's destination address and sequences writes into the three output `router_fifo` instances: header (`lfd_state`), payload, and parity. It stalls the input port while the destination FIFO is full or still draining a previous packet. It sits between the input register stage and the FIFO/synchroniser block, and its Moore outputs drive the register stage and FIFO write path.

---
 rtl/router_fsm_if.sv | 55 +++++
 rtl/router_fsm.sv | 134 +++++++++++++
 tb/tb_router_fsm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// router_fsm_if
// Groups the packet-control handshake between the input register stage,
// the output FIFO block and the router control FSM.
//   master : packet source / register stage / FIFO side (drives status,
//            receives control strobes)
//   slave  : router_fsm (receives status, drives Moore control strobes)
// Signals:
//   pkt_valid        source is presenting header/payload (low on parity)
//   data_in[1:0]     destination address bits of the header byte
//   fifo_full        full flag of the currently addressed FIFO
//   fifo_empty_0..2  per-FIFO empty flags
//   soft_reset_0..2  per-FIFO timeout resets
//   parity_done      register stage has captured the parity byte
//   low_pkt_valid    pkt_valid fell while the FSM was stalled
//   busy, detect_add, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg   control outputs of the FSM
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  busy, detect_add, lfd_state, ld_state, laf_state,
    input  full_state, write_enb_reg, rst_int_reg
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output busy, detect_add, lfd_state, ld_state, laf_state,
    output full_state, write_enb_reg, rst_int_reg
  );
endinterface

// File: rtl/router_fsm.sv
// router_fsm
// Packet-level control FSM of the 1x3 router. Decodes the header address,
// sequences header / payload / parity writes into the addressed output FIFO,
// stalls the source while the FIFO is full or still draining, and abandons
// the packet on a per-FIFO soft reset. All outputs are Moore decodes of the
// state register.
// Ports:
//   clock   system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     router_fsm_if.slave (status inputs, control strobe outputs)
// Parameters:
//   NUM_PORTS  number of destination FIFOs (addresses >= NUM_PORTS dropped)
module router_fsm #(
  parameter int NUM_PORTS = 3
) (
  input  logic         clock,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic [1:0] addr_q;

  logic [3:0] port_mask;
  logic [3:0] empty_vec;
  logic [3:0] soft_vec;
  logic [1:0] sel_addr;
  logic       addr_valid;
  logic       empty_sel;
  logic       soft_sel;

  // One mask bit per 2-bit address value: set only for existing FIFOs.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port_mask
      assign port_mask[gi] = (gi < NUM_PORTS) ? 1'b1 : 1'b0;
    end
  endgenerate

  assign empty_vec = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_vec  = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  // While decoding, the latched address is not yet valid, so the live
  // header bits select the empty/soft-reset flags instead.
  assign sel_addr   = (state_reg == DECODE_ADDRESS) ? bus.data_in : addr_q;
  assign addr_valid = port_mask[bus.data_in];
  assign empty_sel  = empty_vec[sel_addr] & port_mask[sel_addr];
  assign soft_sel   = soft_vec[sel_addr] & port_mask[sel_addr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= DECODE_ADDRESS;
      addr_q    <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE_ADDRESS && bus.pkt_valid) begin
        addr_q <= bus.data_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DECODE_ADDRESS: begin
        // Invalid addresses fall through and the header is dropped.
        if (bus.pkt_valid && addr_valid) begin
          state_next = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_next = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full) begin
          state_next = FIFO_FULL_STATE;
        end else if (!bus.pkt_valid) begin
          state_next = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) begin
          state_next = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done) begin
          state_next = DECODE_ADDRESS;
        end else if (bus.low_pkt_valid) begin
          state_next = LOAD_PARITY;
        end else begin
          state_next = LOAD_DATA;
        end
      end
      LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_sel) begin
          state_next = LOAD_FIRST_DATA;
        end
      end
      default: state_next = DECODE_ADDRESS;
    endcase

    // A timeout on the addressed FIFO abandons the packet from any state
    // that is already committed to a destination.
    if (state_reg != DECODE_ADDRESS && soft_sel) begin
      state_next = DECODE_ADDRESS;
    end
  end

  assign bus.detect_add    = (state_reg == DECODE_ADDRESS);
  assign bus.lfd_state     = (state_reg == LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_reg == LOAD_DATA);
  assign bus.laf_state     = (state_reg == LOAD_AFTER_FULL);
  assign bus.full_state    = (state_reg == FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
  assign bus.write_enb_reg = (state_reg == LOAD_DATA) ||
                             (state_reg == LOAD_PARITY) ||
                             (state_reg == LOAD_AFTER_FULL);
  // Only decode and steady payload loading can accept a new byte per cycle.
  assign bus.busy          = !((state_reg == DECODE_ADDRESS) ||
                               (state_reg == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm
// Table-driven check of router_fsm: each record holds the inputs applied
// for one clock cycle and the outputs expected right after that edge.
// Hand-written sequences cover async reset and the long normal packet.
module tb_router_fsm;

  logic clock;
  logic resetn;
  logic clk_en;

  router_fsm_if bus ();

  router_fsm #(.NUM_PORTS(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = clk_en ? ~clock : clock;

  // Output vector: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
  logic [7:0] outs;
  assign outs = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                 bus.laf_state, bus.full_state, bus.write_enb_reg, bus.rst_int_reg};

  localparam logic [7:0] O_DA  = 8'b0100_0000;
  localparam logic [7:0] O_LFD = 8'b1010_0000;
  localparam logic [7:0] O_LD  = 8'b0001_0010;
  localparam logic [7:0] O_FUL = 8'b1000_0100;
  localparam logic [7:0] O_LAF = 8'b1000_1010;
  localparam logic [7:0] O_LP  = 8'b1000_0010;
  localparam logic [7:0] O_CPE = 8'b1000_0001;
  localparam logic [7:0] O_WTE = 8'b1000_0000;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic pv, input logic [1:0] din, input logic ff,
                     input logic [2:0] emp, input logic [2:0] sr,
                     input logic pd, input logic lpv, input logic [7:0] e);
    vec_t v;
    v.pv = pv; v.din = din; v.ff = ff; v.emp = emp; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.exp_out = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic ff,
                       input logic [2:0] emp, input logic [2:0] sr,
                       input logic pd, input logic lpv);
    bus.pkt_valid     = pv;
    bus.data_in       = din;
    bus.fifo_full     = ff;
    bus.fifo_empty_0  = emp[0];
    bus.fifo_empty_1  = emp[1];
    bus.fifo_empty_2  = emp[2];
    bus.soft_reset_0  = sr[0];
    bus.soft_reset_1  = sr[1];
    bus.soft_reset_2  = sr[2];
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  initial begin
    int lfd_n, ld_n, lp_n, rst_n_cnt, wen_n;

    // ---- vector table ----
    // idle: pkt_valid low keeps decoding
    for (int i = 0; i < 5; i++) add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);
    // busy destination port 2: 6 cycles waiting, then header write
    add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE);
    for (int i = 0; i < 5; i++) add(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    // payload cycles 1..4, full seen at end of 5th, 3 stall cycles
    for (int i = 0; i < 5; i++) add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LD);
    for (int i = 0; i < 3; i++) add(1, 2'd2, 1, 3'b111, 3'b000, 0, 0, O_FUL);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LAF);
    add(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LP);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_CPE);
    add(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_DA);
    // low_pkt_valid during stall -> parity; full in check -> stall; parity_done -> decode
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LAF);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LP);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE);
    add(0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FUL);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
    add(0, 2'd0, 0, 3'b111, 3'b000, 1, 0, O_DA);
    // fifo_full has priority over pkt_valid falling in LOAD_DATA
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    add(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(0, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FUL);
    // soft reset of port 1 during the stall abandons the packet
    add(0, 2'd1, 1, 3'b111, 3'b010, 0, 0, O_DA);
    // invalid address 3 is dropped
    for (int i = 0; i < 3; i++) add(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DA);
    // wait on port 0; foreign soft reset ignored, own soft reset returns
    add(1, 2'd0, 0, 3'b110, 3'b000, 0, 0, O_WTE);
    add(1, 2'd0, 0, 3'b110, 3'b010, 0, 0, O_WTE);
    add(1, 2'd0, 0, 3'b110, 3'b001, 0, 0, O_DA);
    // soft reset is ignored while decoding
    add(1, 2'd0, 0, 3'b111, 3'b001, 0, 0, O_LFD);
    add(1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE);
    add(0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);

    // ---- async reset with no clock running ----
    clock  = 1'b0;
    clk_en = 1'b0;
    resetn = 1'b0;
    drive(0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
    #20;
    check("reset_outputs", {24'd0, outs}, {24'd0, O_DA});
    $display("reset: outs=%b", outs);
    resetn = 1'b1;
    #2;
    clk_en = 1'b1;

    // ---- table ----
    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].din, vecs[i].ff, vecs[i].emp, vecs[i].sr,
            vecs[i].pd, vecs[i].lpv);
      @(posedge clock);
      #1;
      $display("vec %0d: pv=%b din=%0d ff=%b outs=%b exp=%b", i, vecs[i].pv,
               vecs[i].din, vecs[i].ff, outs, vecs[i].exp_out);
      check($sformatf("vec[%0d]", i), {24'd0, outs}, {24'd0, vecs[i].exp_out});
    end

    // ---- normal packet: header to port 1, 14 payload, parity ----
    lfd_n = 0; ld_n = 0; lp_n = 0; rst_n_cnt = 0; wen_n = 0;
    for (int e = 0; e < 18; e++) begin
      drive((e < 15) ? 1'b1 : 1'b0, 2'd1, 0, 3'b111, 3'b000, 0, 0);
      @(posedge clock);
      #1;
      if (bus.lfd_state)     lfd_n++;
      if (bus.ld_state)      ld_n++;
      if (outs == O_LP)      lp_n++;
      if (bus.rst_int_reg)   rst_n_cnt++;
      if (bus.write_enb_reg) wen_n++;
    end
    $display("normal packet: lfd=%0d ld=%0d lp=%0d rst_int=%0d wen=%0d",
             lfd_n, ld_n, lp_n, rst_n_cnt, wen_n);
    check("pkt_lfd_cycles", lfd_n, 1);
    check("pkt_ld_cycles", ld_n, 14);
    check("pkt_parity_cycles", lp_n, 1);
    check("pkt_rst_int_cycles", rst_n_cnt, 1);
    check("pkt_write_cycles", wen_n, 15);
    check("pkt_end_detect_add", {31'd0, bus.detect_add}, 1);

    // ---- async reset mid-packet, between clock edges ----
    drive(1, 2'd0, 0, 3'b111, 3'b000, 0, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midpkt_in_load_data", {24'd0, outs}, {24'd0, O_LD});
    #2;
    resetn = 1'b0;
    #1;
    check("midpkt_async_reset", {24'd0, outs}, {24'd0, O_DA});
    $display("mid-packet reset: outs=%b", outs);
    @(negedge clock);
    resetn = 1'b1;
    drive(0, 2'd0, 0, 3'b111, 3'b000, 0, 0);
    @(posedge clock); #1;
    check("post_reset_idle", {24'd0, outs}, {24'd0, O_DA});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
